// File: rtl/palette_engine.sv
// Indexed-colour palette with a colour-cycling index window and a frame-stepped fade.
// Lookup is two registered stages: palette fetch, then per-channel brightness scaling.

module palette_engine_scale #(
  parameter int CH_W   = 6,
  parameter int FADE_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CH_W-1:0] c,
  input  logic [FADE_W:0] lvl,
  output logic [CH_W-1:0] q
);
  localparam int P_W = CH_W + FADE_W + 1;

  logic [P_W-1:0] prod;

  // full-precision product; L = 2^FADE_W reproduces c exactly after the shift
  assign prod = P_W'(c) * P_W'(lvl);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else        q <= CH_W'(prod >> FADE_W);
endmodule

module palette_engine #(
  parameter int IDX_W     = 3,
  parameter int CH_W      = 6,
  parameter int FADE_W    = 4,
  parameter int CYCLE_LO  = 2,
  parameter int CYCLE_HI  = 5,
  parameter int CYCLE_DIV = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [3*CH_W-1:0] wr_rgb,
  input  logic [IDX_W-1:0]  color,
  input  logic              frame_tick,
  input  logic              cycle_en,
  input  logic              fade_start,
  input  logic              fade_dir,
  output logic [CH_W-1:0]   r,
  output logic [CH_W-1:0]   g,
  output logic [CH_W-1:0]   b,
  output logic              fade_busy
);
  localparam int N     = 1 << IDX_W;
  localparam int LEN   = CYCLE_HI - CYCLE_LO + 1;
  localparam int DIV_W = (CYCLE_DIV > 1) ? $clog2(CYCLE_DIV) : 1;
  localparam int L_W   = FADE_W + 1;

  localparam logic [IDX_W:0]   LO_X     = (IDX_W+1)'(CYCLE_LO);
  localparam logic [IDX_W:0]   HI_X     = (IDX_W+1)'(CYCLE_HI);
  localparam logic [IDX_W:0]   LEN_X    = (IDX_W+1)'(LEN);
  localparam logic [IDX_W-1:0] OFF_LAST = IDX_W'(LEN - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CYCLE_DIV - 1);
  localparam logic [L_W-1:0]   L_MAX    = L_W'(1 << FADE_W);

  typedef enum logic [1:0] {IDLE, IN, OUT} fade_st_t;

  logic [N-1:0][3*CH_W-1:0] pal;
  logic [2:0][CH_W-1:0]     ent;
  logic [2:0][CH_W-1:0]     px;
  logic [IDX_W-1:0]         off;
  logic [DIV_W-1:0]         div;
  logic                     in_cyc;
  logic [IDX_W:0]           rel;
  logic [IDX_W-1:0]         eff;
  fade_st_t                 st, st_nx;
  logic [L_W-1:0]           lvl, lvl_nx;

  // rotation: divider counts frame_ticks, offset steps on the last one; both freeze when disabled
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      off <= '0;
      div <= '0;
    end else if (cycle_en && frame_tick) begin
      if (div == DIV_LAST) begin
        div <= '0;
        off <= (off == OFF_LAST) ? '0 : off + 1'b1;
      end else begin
        div <= div + 1'b1;
      end
    end

  // rel never exceeds 2*LEN-2, so one conditional subtract is the modulo
  always_comb begin
    in_cyc = ({1'b0, color} >= LO_X) && ({1'b0, color} <= HI_X);
    rel    = {1'b0, color} - LO_X + {1'b0, off};
    if (rel >= LEN_X) rel = rel - LEN_X;
    eff    = in_cyc ? IDX_W'(rel + LO_X) : color;
  end

  // stage 1 reads the pre-write contents, giving old data on a same-entry write
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pal <= '0;
      ent <= '0;
    end else begin
      ent <= pal[eff];
      if (wr_en) pal[wr_idx] <= wr_rgb;
    end

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    palette_engine_scale #(.CH_W(CH_W), .FADE_W(FADE_W)) u_scale (
      .clk   (clk),
      .rst_n (rst_n),
      .c     (ent[ch]),
      .lvl   (lvl),
      .q     (px[ch])
    );
  end

  assign r = px[2];
  assign g = px[1];
  assign b = px[0];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st  <= IDLE;
      lvl <= L_MAX;
    end else begin
      st  <= st_nx;
      lvl <= lvl_nx;
    end

  // fade_start overrides a coincident frame_tick; the level never steps past its limit
  always_comb begin
    st_nx  = st;
    lvl_nx = lvl;
    if (fade_start) begin
      st_nx = fade_dir ? IN : OUT;
    end else if (frame_tick) begin
      case (st)
        IN: begin
          if (lvl != L_MAX) lvl_nx = lvl + 1'b1;
          if (lvl >= L_MAX - 1'b1) st_nx = IDLE;
        end
        OUT: begin
          if (lvl != '0) lvl_nx = lvl - 1'b1;
          if (lvl <= L_W'(1)) st_nx = IDLE;
        end
        default: ;
      endcase
    end
  end

  assign fade_busy = (st != IDLE);
endmodule

// File: tb/tb_palette_engine.sv
// Self-checking bench for palette_engine: directed scenarios plus random traffic
// compared against an array/integer model of the palette, rotation and fade rules.

module tb_palette_engine;
  localparam int IDX_W = 3, CH_W = 6, FADE_W = 4;
  localparam int LO = 2, HI = 5, DIV = 2;
  localparam int N = 8, LEN = HI - LO + 1, LMAX = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [IDX_W-1:0]  wr_idx = '0;
  logic [3*CH_W-1:0] wr_rgb = '0;
  logic [IDX_W-1:0]  color = '0;
  logic              frame_tick = 1'b0;
  logic              cycle_en = 1'b0;
  logic              fade_start = 1'b0;
  logic              fade_dir = 1'b0;
  logic [CH_W-1:0]   r, g, b;
  logic              fade_busy;

  int total = 0;
  int bad = 0;

  // reference model state
  logic [3*CH_W-1:0] m_pal [N];
  logic [3*CH_W-1:0] m_fetched;
  int                m_off, m_div, m_lvl, m_mode;  // mode: 0 idle, 1 fading in, 2 fading out
  logic [CH_W-1:0]   exp_r, exp_g, exp_b;
  logic              exp_busy;

  palette_engine #(
    .IDX_W(IDX_W), .CH_W(CH_W), .FADE_W(FADE_W),
    .CYCLE_LO(LO), .CYCLE_HI(HI), .CYCLE_DIV(DIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_rgb     (wr_rgb),
    .color      (color),
    .frame_tick (frame_tick),
    .cycle_en   (cycle_en),
    .fade_start (fade_start),
    .fade_dir   (fade_dir),
    .r          (r),
    .g          (g),
    .b          (b),
    .fade_busy  (fade_busy)
  );

  always #5 clk = ~clk;

  function automatic int remap(int c, int off);
    if (c >= LO && c <= HI) return LO + ((c - LO + off) % LEN);
    return c;
  endfunction

  function automatic logic [CH_W-1:0] fade(logic [CH_W-1:0] c, int lvl);
    return CH_W'((int'(c) * lvl) / LMAX);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_pal[i] = '0;
    m_fetched = '0;
    m_off = 0; m_div = 0; m_lvl = LMAX; m_mode = 0;
    exp_r = '0; exp_g = '0; exp_b = '0; exp_busy = 1'b0;
  endtask

  // advance the model one clock using the inputs present at the edge
  task automatic model_step();
    logic [3*CH_W-1:0] look;
    look  = m_pal[remap(int'(color), m_off)];
    exp_r = fade(m_fetched[17:12], m_lvl);
    exp_g = fade(m_fetched[11:6], m_lvl);
    exp_b = fade(m_fetched[5:0], m_lvl);
    m_fetched = look;
    if (wr_en) m_pal[wr_idx] = wr_rgb;
    if (cycle_en && frame_tick) begin
      m_div++;
      if (m_div == DIV) begin
        m_div = 0;
        m_off = (m_off + 1) % LEN;
      end
    end
    if (fade_start) begin
      m_mode = fade_dir ? 1 : 2;
    end else if (frame_tick && m_mode == 1) begin
      if (m_lvl < LMAX) m_lvl++;
      if (m_lvl == LMAX) m_mode = 0;
    end else if (frame_tick && m_mode == 2) begin
      if (m_lvl > 0) m_lvl--;
      if (m_lvl == 0) m_mode = 0;
    end
    exp_busy = (m_mode != 0);
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; frame_tick = 1'b0; fade_start = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    cycle_en = 1'b0; color = '0; fade_dir = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic write_ent(int idx, int rv, int gv, int bv);
    wr_en = 1'b1; wr_idx = IDX_W'(idx);
    wr_rgb = {CH_W'(rv), CH_W'(gv), CH_W'(bv)};
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({r, g, b, fade_busy} !== '0) begin
      bad++;
      $display("FAIL reset_out: got r=%0d g=%0d b=%0d busy=%0b, want all 0", r, g, b, fade_busy);
    end
    color = 3'd6;
    cyc(); cyc();
    total++;
    if ({r, g, b} !== '0) begin
      bad++;
      $display("FAIL reset_palette: got r=%0d g=%0d b=%0d, want 0", r, g, b);
    end
  endtask

  task automatic test_lookup();
    do_reset();
    write_ent(1, 63, 32, 5);
    color = 3'd1;
    cyc();
    total++;
    if ({r, g, b} !== '0) begin
      bad++;
      $display("FAIL lookup_early: got r=%0d g=%0d b=%0d at +1, want 0", r, g, b);
    end
    cyc();
    total++;
    if ({r, g, b} !== {6'd63, 6'd32, 6'd5}) begin
      bad++;
      $display("FAIL lookup_lat2: got r=%0d g=%0d b=%0d, want 63/32/5", r, g, b);
    end
  endtask

  task automatic test_rotation();
    int seq [9];
    seq = '{10, 10, 20, 20, 30, 30, 40, 40, 10};
    do_reset();
    for (int i = 0; i < 4; i++) write_ent(2 + i, 10 * (i + 1), 0, 0);
    write_ent(6, 50, 0, 0);
    cycle_en = 1'b1;
    color = 3'd2;
    cyc(); cyc();
    for (int k = 0; k < 9; k++) begin
      if (k > 0) begin
        tick();
        cyc();
      end
      total++;
      if (r !== CH_W'(seq[k])) begin
        bad++;
        $display("FAIL rotation_step%0d: got r=%0d, want %0d", k, r, seq[k]);
      end
    end
    tick();
    color = 3'd6;
    cyc(); cyc();
    total++;
    if (r !== 6'd50) begin
      bad++;
      $display("FAIL rotation_outside: got r=%0d for color 6, want 50", r);
    end
  endtask

  task automatic test_fade();
    do_reset();
    write_ent(1, 63, 32, 5);
    color = 3'd1;
    fade_dir = 1'b0; fade_start = 1'b1;
    cyc();
    fade_start = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    total++;
    if ({r, g, b, fade_busy} !== {6'd47, 6'd24, 6'd3, 1'b1}) begin
      bad++;
      $display("FAIL fade_out4: got r=%0d g=%0d b=%0d busy=%0b, want 47/24/3 busy=1", r, g, b, fade_busy);
    end
    for (int i = 5; i <= 16; i++) begin
      tick();
      if (i == 15) begin
        total++;
        if ({r, fade_busy} !== {6'd3, 1'b1}) begin
          bad++;
          $display("FAIL fade_out15: got r=%0d busy=%0b, want r=3 busy=1", r, fade_busy);
        end
      end
    end
    total++;
    if ({r, g, b, fade_busy} !== '0) begin
      bad++;
      $display("FAIL fade_out16: got r=%0d g=%0d b=%0d busy=%0b, want 0 busy=0", r, g, b, fade_busy);
    end
    tick();
    total++;
    if ({r, fade_busy} !== '0) begin
      bad++;
      $display("FAIL fade_out17: got r=%0d busy=%0b, want r=0 busy=0", r, fade_busy);
    end
  endtask

  task automatic test_restart();
    do_reset();
    write_ent(1, 63, 0, 0);
    color = 3'd1;
    fade_dir = 1'b0; fade_start = 1'b1;
    cyc();
    fade_start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    fade_dir = 1'b1; fade_start = 1'b1; frame_tick = 1'b1;
    cyc();
    idle_inputs();
    cyc();
    total++;
    if ({r, fade_busy} !== {6'd31, 1'b1}) begin
      bad++;
      $display("FAIL restart_hold: got r=%0d busy=%0b, want r=31 busy=1", r, fade_busy);
    end
    for (int i = 0; i < 7; i++) tick();
    total++;
    if ({r, fade_busy} !== {6'd59, 1'b1}) begin
      bad++;
      $display("FAIL restart_15: got r=%0d busy=%0b, want r=59 busy=1", r, fade_busy);
    end
    tick();
    total++;
    if ({r, fade_busy} !== {6'd63, 1'b0}) begin
      bad++;
      $display("FAIL restart_done: got r=%0d busy=%0b, want r=63 busy=0", r, fade_busy);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    write_ent(3, 11, 22, 33);
    wr_en = 1'b1; wr_idx = 3'd3; wr_rgb = {6'd44, 6'd55, 6'd7};
    color = 3'd3;
    cyc();
    wr_en = 1'b0; color = 3'd0;
    cyc();
    total++;
    if ({r, g, b} !== {6'd11, 6'd22, 6'd33}) begin
      bad++;
      $display("FAIL same_cycle_old: got r=%0d g=%0d b=%0d, want 11/22/33", r, g, b);
    end
    color = 3'd3;
    cyc(); cyc();
    total++;
    if ({r, g, b} !== {6'd44, 6'd55, 6'd7}) begin
      bad++;
      $display("FAIL same_cycle_new: got r=%0d g=%0d b=%0d, want 44/55/7", r, g, b);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    write_ent(1, 63, 32, 5);
    write_ent(2, 10, 0, 0);
    write_ent(4, 40, 0, 0);
    color = 3'd1;
    cycle_en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    cycle_en = 1'b0;
    fade_dir = 1'b0; fade_start = 1'b1;
    cyc();
    fade_start = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    total++;
    if ({r, fade_busy} !== {6'd19, 1'b1}) begin
      bad++;
      $display("FAIL mid_prefade: got r=%0d busy=%0b, want r=19 busy=1", r, fade_busy);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({r, g, b, fade_busy} !== '0) begin
      bad++;
      $display("FAIL mid_reset_out: got r=%0d g=%0d b=%0d busy=%0b, want 0", r, g, b, fade_busy);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    write_ent(2, 10, 0, 0);
    write_ent(4, 40, 0, 0);
    color = 3'd2;
    cyc(); cyc();
    total++;
    if ({r, fade_busy} !== {6'd10, 1'b0}) begin
      bad++;
      $display("FAIL mid_after_release: got r=%0d busy=%0b, want r=10 (off 0, L 16) busy=0", r, fade_busy);
    end
    color = 3'd1;
    cyc(); cyc();
    total++;
    if (r !== 6'd0) begin
      bad++;
      $display("FAIL mid_palette_clear: got r=%0d, want 0", r);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 800; n++) begin
      wr_en      = ($urandom_range(3) == 0);
      wr_idx     = IDX_W'($urandom);
      wr_rgb     = (3*CH_W)'($urandom);
      color      = IDX_W'($urandom);
      frame_tick = ($urandom_range(2) == 0);
      cycle_en   = ($urandom_range(7) != 0);
      fade_start = ($urandom_range(24) == 0);
      fade_dir   = 1'($urandom);
      cyc();
      total++;
      if ({r, g, b, fade_busy} !== {exp_r, exp_g, exp_b, exp_busy}) begin
        bad++;
        $display("FAIL random_cyc%0d: got r=%0d g=%0d b=%0d busy=%0b, want r=%0d g=%0d b=%0d busy=%0b",
                 n, r, g, b, fade_busy, exp_r, exp_g, exp_b, exp_busy);
      end
    end
    idle_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lookup();
    test_rotation();
    test_fade();
    test_restart();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
